// File: rtl/wb_stream_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS stream DMA masters share one memory port, grant held for a whole cyc.
// Optional watchdog for hung slaves is enabled by defining WB_STREAM_ARBITER_WATCHDOG_EN.
module wb_stream_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int WB_AW       = 32,
  parameter int WB_DW       = 32,
  parameter int TIMEOUT     = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS*WB_AW-1:0]  wbm_adr_i,
  input  logic [NUM_MASTERS*WB_DW-1:0]  wbm_dat_i,
  input  logic [NUM_MASTERS*WB_DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]        wbm_we_i,
  input  logic [NUM_MASTERS-1:0]        wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]        wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]      wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]      wbm_bte_i,
  output logic [WB_DW-1:0]              wbm_dat_o,
  output logic [NUM_MASTERS-1:0]        wbm_ack_o,
  output logic [NUM_MASTERS-1:0]        wbm_err_o,
  output logic [NUM_MASTERS-1:0]        wbm_rty_o,
  output logic [WB_AW-1:0]              wbs_adr_o,
  output logic [WB_DW-1:0]              wbs_dat_o,
  output logic [WB_DW/8-1:0]            wbs_sel_o,
  output logic                          wbs_we_o,
  output logic                          wbs_cyc_o,
  output logic                          wbs_stb_o,
  output logic [2:0]                    wbs_cti_o,
  output logic [1:0]                    wbs_bte_o,
  input  logic [WB_DW-1:0]              wbs_dat_i,
  input  logic                          wbs_ack_i,
  input  logic                          wbs_err_i,
  input  logic                          wbs_rty_i,
  output logic [NUM_MASTERS-1:0]        gnt_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW    = WB_DW / 8;

  if (NUM_MASTERS < 1 || NUM_MASTERS > 8 || TIMEOUT < 1) begin : g_cfg_check
    $error("wb_stream_arbiter: unsupported NUM_MASTERS or TIMEOUT");
  end

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                 state, state_n;
  logic [NUM_MASTERS-1:0] gnt, gnt_n;
  logic [IDX_W-1:0]       last, last_n, pick;
  logic                   pick_vld;
  logic [NUM_MASTERS-1:0] req;
  logic                   active, wd_fire;

  logic [WB_AW-1:0] g_adr;
  logic [WB_DW-1:0] g_dat;
  logic [SW-1:0]    g_sel;
  logic [2:0]       g_cti;
  logic [1:0]       g_bte;
  logic             g_we, g_cyc, g_stb;

  assign active = (state == GRANT);

  // 'last' doubles as the index of the current grantee while in GRANT.
  always_comb begin
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_cti = '0;
    g_bte = '0;
    g_we  = 1'b0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (last == IDX_W'(i)) begin
        g_adr = wbm_adr_i[i*WB_AW +: WB_AW];
        g_dat = wbm_dat_i[i*WB_DW +: WB_DW];
        g_sel = wbm_sel_i[i*SW +: SW];
        g_cti = wbm_cti_i[i*3 +: 3];
        g_bte = wbm_bte_i[i*2 +: 2];
        g_we  = wbm_we_i[i];
        g_cyc = wbm_cyc_i[i];
        g_stb = wbm_stb_i[i];
      end
    end
  end

  // Round-robin: first requester above 'last', else wrap to the lowest at or below it.
  always_comb begin
    pick     = last;
    pick_vld = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!pick_vld && req[i] && (IDX_W'(i) > last)) begin
        pick     = IDX_W'(i);
        pick_vld = 1'b1;
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!pick_vld && req[i] && (IDX_W'(i) <= last)) begin
        pick     = IDX_W'(i);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    last_n  = last;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_n = GRANT;
          last_n  = pick;
          for (int i = 0; i < NUM_MASTERS; i++) gnt_n[i] = (pick == IDX_W'(i));
        end
      end
      GRANT: begin
        if (!g_cyc || wd_fire) begin
          state_n = IDLE;
          gnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      last  <= last_n;
    end
  end

`ifdef WB_STREAM_ARBITER_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0]       wd_cnt;
  logic [NUM_MASTERS-1:0] wd_mask;
  logic                   wd_resp, wd_stall;

  assign wd_resp  = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign wd_stall = active & g_cyc & g_stb & ~wd_resp;
  assign wd_fire  = wd_stall && (wd_cnt == CNT_W'(TIMEOUT - 1));
  // A timed-out master stays out of arbitration until it drops cyc.
  assign req      = wbm_cyc_i & ~wd_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      wd_mask <= '0;
    end else begin
      if (!active || wd_resp || wd_fire) wd_cnt <= '0;
      else if (wd_stall)                 wd_cnt <= wd_cnt + 1'b1;
      wd_mask <= (wd_mask & wbm_cyc_i) | (wd_fire ? gnt : '0);
    end
  end
`else
  assign wd_fire = 1'b0;
  assign req     = wbm_cyc_i;
`endif

  assign wbs_adr_o = g_adr;
  assign wbs_dat_o = g_dat;
  assign wbs_sel_o = active ? g_sel : '0;
  assign wbs_cti_o = active ? g_cti : '0;
  assign wbs_bte_o = active ? g_bte : '0;
  assign wbs_we_o  = active & g_we;
  assign wbs_cyc_o = active & g_cyc & ~wd_fire;
  assign wbs_stb_o = active & g_stb & ~wd_fire;
  assign wbm_dat_o = wbs_dat_i;
  assign gnt_o     = gnt;

  always_comb begin
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      wbm_ack_o[i] = active & gnt[i] & wbs_ack_i;
      wbm_err_o[i] = active & gnt[i] & (wbs_err_i | wd_fire);
      wbm_rty_o[i] = active & gnt[i] & wbs_rty_i;
    end
  end

endmodule

// File: tb/tb_wb_stream_arbiter.sv
// Bench for wb_stream_arbiter: vector table, hand-written corner sequences and random traffic
// checked every cycle against an ownership-based reference model.
module tb_wb_stream_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;
`ifdef WB_STREAM_ARBITER_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam logic [N-1:0] ONE = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]  m_cyc = '0, m_stb = '0, m_we = '0;
  logic [AW-1:0] m_adr [N];
  logic [DW-1:0] m_dat [N];
  logic [SW-1:0] m_sel [N];
  logic [2:0]    m_cti [N];
  logic [1:0]    m_bte [N];
  logic [DW-1:0] s_dat = '0;
  logic          s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

  logic [N*AW-1:0] wbm_adr_i;
  logic [N*DW-1:0] wbm_dat_i;
  logic [N*SW-1:0] wbm_sel_i;
  logic [N*3-1:0]  wbm_cti_i;
  logic [N*2-1:0]  wbm_bte_i;
  logic [DW-1:0]   wbm_dat_o;
  logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o, gnt_o;
  logic [AW-1:0]   wbs_adr_o;
  logic [DW-1:0]   wbs_dat_o;
  logic [SW-1:0]   wbs_sel_o;
  logic            wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]      wbs_cti_o;
  logic [1:0]      wbs_bte_o;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      wbm_adr_i[i*AW +: AW] = m_adr[i];
      wbm_dat_i[i*DW +: DW] = m_dat[i];
      wbm_sel_i[i*SW +: SW] = m_sel[i];
      wbm_cti_i[i*3 +: 3]   = m_cti[i];
      wbm_bte_i[i*2 +: 2]   = m_bte[i];
    end
  end

  wb_stream_arbiter #(.NUM_MASTERS(N), .WB_AW(AW), .WB_DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(m_we), .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .gnt_o(gnt_o)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // Reference model: who owns the bus (-1 = nobody), who owned it last, stalled cycles, timed-out masters.
  int           mo_owner = -1;
  int           mo_last  = N - 1;
  int           mo_stall = 0;
  logic [N-1:0] mo_mask  = '0;

  function automatic logic mo_fire();
    return WD && (mo_owner >= 0) && bit_of(m_cyc, mo_owner) && bit_of(m_stb, mo_owner)
           && !(s_ack || s_err || s_rty) && (mo_stall == TO - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_update
    logic         f;
    logic [N-1:0] req, new_mask;
    int           pick;
    if (!rst_n) begin
      mo_owner = -1;
      mo_last  = N - 1;
      mo_stall = 0;
      mo_mask  = '0;
    end else begin
      f        = mo_fire();
      req      = m_cyc & ~mo_mask;
      new_mask = mo_mask & m_cyc;
      if (f) new_mask = new_mask | (ONE << mo_owner);
      if (mo_owner < 0) begin
        pick = -1;
        for (int k = 1; k <= N; k++)
          if (pick < 0 && bit_of(req, (mo_last + k) % N)) pick = (mo_last + k) % N;
        if (pick >= 0) begin
          mo_owner = pick;
          mo_last  = pick;
        end
        mo_stall = 0;
      end else if (f || !bit_of(m_cyc, mo_owner)) begin
        mo_owner = -1;
        mo_stall = 0;
      end else if (s_ack || s_err || s_rty) begin
        mo_stall = 0;
      end else if (bit_of(m_stb, mo_owner)) begin
        mo_stall = mo_stall + 1;
      end
      mo_mask = new_mask;
    end
  end

  always @(negedge clk) begin : model_check
    logic         f, e_cyc, e_stb, own;
    logic [N-1:0] e_gnt, e_ack, e_err, e_rty;
    f     = mo_fire();
    own   = (mo_owner >= 0);
    e_gnt = own ? (ONE << mo_owner) : '0;
    e_cyc = own && bit_of(m_cyc, mo_owner) && !f;
    e_stb = own && bit_of(m_stb, mo_owner) && !f;
    e_ack = (own && s_ack) ? e_gnt : '0;
    e_err = (own && (s_err || f)) ? e_gnt : '0;
    e_rty = (own && s_rty) ? e_gnt : '0;
    chk("m_gnt", gnt_o, e_gnt);
    chk("m_wbs_cyc", wbs_cyc_o, e_cyc);
    chk("m_wbs_stb", wbs_stb_o, e_stb);
    chk("m_ack", wbm_ack_o, e_ack);
    chk("m_err", wbm_err_o, e_err);
    chk("m_rty", wbm_rty_o, e_rty);
    chk("m_dat_o", wbm_dat_o, s_dat);
    chk("m_we", wbs_we_o, own ? m_we[mo_owner] : 1'b0);
    chk("m_cti", wbs_cti_o, own ? m_cti[mo_owner] : 3'd0);
    chk("m_bte", wbs_bte_o, own ? m_bte[mo_owner] : 2'd0);
    chk("m_sel", wbs_sel_o, own ? m_sel[mo_owner] : '0);
    if (e_cyc) begin
      chk("m_adr", wbs_adr_o, m_adr[mo_owner]);
      chk("m_dat", wbs_dat_o, m_dat[mo_owner]);
    end
  end

  typedef struct {
    logic [1:0] cyc;
    logic       ack;
    logic       err;
    logic [1:0] gnt;
    logic       wcyc;
    logic [1:0] mack;
    logic [1:0] merr;
  } vec_t;
  vec_t tv [19];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle(input int n);
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    for (int i = 0; i < N; i++) m_cti[i] = 3'd0;
    repeat (n) next_cycle();
  endtask

  int           rem [N];
  logic [N-1:0] acked = '0;
  bit           seen;
  int           g_cycles;

  initial begin
    for (int i = 0; i < N; i++) begin
      m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = '0; m_cti[i] = '0; m_bte[i] = '0; rem[i] = 0;
    end
    // Requests held during reset must not leak through.
    m_cyc = 2'b11;
    m_stb = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_cyc", wbs_cyc_o, 1'b0);
    chk("rst_ack", wbm_ack_o, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    tv[0]  = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
    tv[1]  = '{2'b11, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 2'b00};
    tv[2]  = '{2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 2'b01, 2'b00};
    tv[3]  = '{2'b10, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00};
    tv[4]  = '{2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
    tv[5]  = '{2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 2'b00, 2'b00};
    tv[6]  = '{2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00};
    tv[7]  = '{2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 2'b00};
    tv[8]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
    tv[9]  = '{2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
    tv[10] = '{2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 2'b00, 2'b00};
    tv[11] = '{2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 2'b00, 2'b00};
    tv[12] = '{2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00};
    tv[13] = '{2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 2'b00};
    tv[14] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
    tv[15] = '{2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
    tv[16] = '{2'b01, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 2'b01};
    tv[17] = '{2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00};
    tv[18] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};

    m_adr[0] = 32'h200;
    m_adr[1] = 32'h100;
    m_we     = 2'b10;
    for (int r = 0; r < 19; r++) begin
      m_cyc = tv[r].cyc;
      m_stb = tv[r].cyc;
      s_ack = tv[r].ack;
      s_err = tv[r].err;
      @(negedge clk);
      chk($sformatf("tv%0d_gnt", r), gnt_o, tv[r].gnt);
      chk($sformatf("tv%0d_cyc", r), wbs_cyc_o, tv[r].wcyc);
      chk($sformatf("tv%0d_ack", r), wbm_ack_o, tv[r].mack);
      chk($sformatf("tv%0d_err", r), wbm_err_o, tv[r].merr);
      if (tv[r].wcyc) chk($sformatf("tv%0d_adr", r), wbs_adr_o, (tv[r].gnt == 2'b10) ? 32'h100 : 32'h200);
      next_cycle();
    end
    go_idle(1);

    // Burst from master 0 must not be split by master 1's request.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cti[0] = 3'b010; m_adr[0] = 32'h1000;
    next_cycle();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h2000;
    s_ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m_cti[0] = (b == 3) ? 3'b111 : 3'b010;
      m_adr[0] = 32'h1000 + 32'(4 * b);
      @(negedge clk);
      chk("burst_gnt", gnt_o, 2'b01);
      chk("burst_cti", wbs_cti_o, (b == 3) ? 3'b111 : 3'b010);
      chk("burst_adr", wbs_adr_o, 32'h1000 + 32'(4 * b));
      chk("burst_ack", wbm_ack_o, 2'b01);
      next_cycle();
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cti[0] = 3'd0; s_ack = 1'b0;
    @(negedge clk);
    chk("burst_rel_cyc", wbs_cyc_o, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("burst_dead", gnt_o, 2'b00);
    next_cycle();
    @(negedge clk);
    chk("burst_m1_gnt", gnt_o, 2'b10);
    chk("burst_m1_adr", wbs_adr_o, 32'h2000);
    go_idle(2);

    // Reset in the middle of master 0's burst.
    m_cyc = 2'b01; m_stb = 2'b01; m_cti[0] = 3'b010;
    next_cycle();
    s_ack = 1'b1;
    next_cycle();
    s_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_cyc", wbs_cyc_o, 1'b0);
    chk("rstmid_gnt", gnt_o, 2'b00);
    chk("rstmid_stb", wbs_stb_o, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    m_cyc = 2'b11; m_stb = 2'b11; m_cti[0] = 3'd0;
    @(negedge clk);
    chk("rstrel_idle", gnt_o, 2'b00);
    next_cycle();
    @(negedge clk);
    chk("rst_prio", gnt_o, 2'b01);
    go_idle(2);

    // Random traffic; masters react to their own terminations.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_cyc[i]) begin
          if (acked[i]) begin
            rem[i]--;
            if (rem[i] == 0) begin
              m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_cti[i] = 3'd0;
            end else begin
              m_cti[i] = (rem[i] == 1) ? 3'b111 : 3'b010;
              m_adr[i] = m_adr[i] + 32'd4;
              m_dat[i] = $urandom;
            end
          end
        end else if ($urandom_range(0, 2) == 0) begin
          rem[i]   = $urandom_range(1, 4);
          m_cyc[i] = 1'b1;
          m_stb[i] = 1'b1;
          m_we[i]  = 1'($urandom_range(0, 1));
          m_adr[i] = $urandom;
          m_dat[i] = $urandom;
          m_sel[i] = SW'($urandom_range(0, 15));
          m_bte[i] = 2'($urandom_range(0, 3));
          m_cti[i] = (rem[i] == 1) ? 3'b111 : 3'b010;
        end
      end
      begin
        int r;
        r = $urandom_range(0, 9);
        s_ack = (r < 6);
        s_err = (r == 6);
        s_rty = (r == 7);
        s_dat = $urandom;
      end
      @(negedge clk);
      acked = wbm_ack_o | wbm_err_o | wbm_rty_o;
      next_cycle();
    end
    go_idle(3);

`ifdef WB_STREAM_ARBITER_WATCHDOG_EN
    // Hung slave: master 0 never acked, master 1 waiting.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h300;
    next_cycle();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h400;
    seen = 1'b0;
    g_cycles = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (gnt_o == 2'b01) g_cycles++;
      if (wbm_err_o[0]) begin
        seen = 1'b1;
        chk("wd_cycle", g_cycles, TO);
        chk("wd_cyc_forced", wbs_cyc_o, 1'b0);
        chk("wd_err_iso", wbm_err_o, 2'b01);
      end
      next_cycle();
    end
    chk("wd_seen", seen, 1'b1);
    @(negedge clk);
    chk("wd_dead", gnt_o, 2'b00);
    next_cycle();
    @(negedge clk);
    chk("wd_next", gnt_o, 2'b10);
    next_cycle();
    s_ack = 1'b1;
    next_cycle();
    s_ack = 1'b0;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("wd_mask", gnt_o, 2'b00);
      next_cycle();
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    next_cycle();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("wd_unmask", gnt_o, 2'b01);
    go_idle(2);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", n_bad + 1);
    $fatal(1, "bench timeout");
  end

endmodule
